// File: rtl/pe_feed_ctrl_pkg.sv
// ============================================================================
// pe_feed_ctrl_pkg : shared types, widths and helpers for the PE feed controller
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef CNN_XLEN
`define CNN_XLEN 8
`endif
`ifndef ADDR_B
`define ADDR_B 2
`endif
`ifndef ICP_NUM
`define ICP_NUM 4
`endif
`ifndef SD
`define SD
`endif

package pe_feed_ctrl_pkg;

    localparam int DATA_WID  = `CNN_XLEN;
    localparam int ADDR_B    = `ADDR_B;
    localparam int MUL_NUM   = `ICP_NUM;
    localparam int RUN_B     = 16;
    localparam int DRAIN_CYC = 3;
    localparam int LANE_W    = (MUL_NUM > 1) ? $clog2(MUL_NUM) : 1;

    typedef enum logic [1:0] {
        PE_INVALID = 2'd0,
        PE_LOAD    = 2'd1,
        PE_COMPUTE = 2'd2,
        PE_LAST    = 2'd3
    } PE_STATE;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_LOAD  = 2'd1,
        FS_RUN   = 2'd2,
        FS_DRAIN = 2'd3
    } FEED_STATE;

    typedef struct packed {
        PE_STATE                       PE_state;
        logic [MUL_NUM-1:0]            wrb;
        logic [ADDR_B-1:0]             wrb_addr;
        logic [DATA_WID-1:0]           wrb_data;
        logic [ADDR_B-1:0]             rdb_addr;
        logic [MUL_NUM*DATA_WID-1:0]   A;
    } PE_IN_PACKET;

    function automatic logic [MUL_NUM-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
        logic [MUL_NUM-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_feed_if.sv
// ============================================================================
// pe_feed_if : weight/activation streams and the PE input packet bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pe_feed_if;
    import pe_feed_ctrl_pkg::*;

    logic                          wt_valid;
    logic [DATA_WID-1:0]           wt_data;
    logic                          wt_ready;
    logic                          act_valid;
    logic [MUL_NUM*DATA_WID-1:0]   act_data;
    logic                          act_ready;
    PE_IN_PACKET                   pe_in_pk;

    // master: the feed controller producing packets
    modport master (
        input  wt_valid,
        input  wt_data,
        input  act_valid,
        input  act_data,
        output wt_ready,
        output act_ready,
        output pe_in_pk
    );

    modport slave (
        output wt_valid,
        output wt_data,
        output act_valid,
        output act_data,
        input  wt_ready,
        input  act_ready,
        input  pe_in_pk
    );

endinterface

`default_nettype wire

// File: rtl/pe_feed_ctrl_addr_gen.sv
// ============================================================================
// pe_feed_addr_gen : lane/address counters for LOAD and read-address wrap for RUN
// Revision: 1.0
// ============================================================================
`default_nettype none

module pe_feed_addr_gen
    import pe_feed_ctrl_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 clear,
    input  wire logic                 wt_fire,
    input  wire logic                 act_fire,
    input  wire logic [ADDR_B:0]      num_w,
    output      logic [LANE_W-1:0]    lane_cnt,
    output      logic [ADDR_B-1:0]    wr_addr,
    output      logic [ADDR_B-1:0]    rd_cnt,
    output      logic                 wt_last
);

    localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(MUL_NUM - 1);
    localparam logic [ADDR_B:0]   ADDR_ONE = (ADDR_B + 1)'(1);
    localparam logic [ADDR_B-1:0] RD_ONE   = ADDR_B'(1);

    logic [ADDR_B:0] addr_cnt;
    logic            lane_wrap;
    logic            addr_last;
    logic            rd_wrap;

    // addr_cnt is one bit wider so a full-depth load (num_w = 2**ADDR_B) compares cleanly
    assign lane_wrap = (lane_cnt == LANE_MAX);
    assign addr_last = (addr_cnt == (num_w - ADDR_ONE));
    assign rd_wrap   = ({1'b0, rd_cnt} == (num_w - ADDR_ONE));
    assign wt_last   = wt_fire & lane_wrap & addr_last;
    assign wr_addr   = addr_cnt[ADDR_B-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt <= `SD '0;
            addr_cnt <= `SD '0;
            rd_cnt   <= `SD '0;
        end else if (clear) begin
            lane_cnt <= `SD '0;
            addr_cnt <= `SD '0;
            rd_cnt   <= `SD '0;
        end else begin
            if (wt_fire) begin
                if (lane_wrap) begin
                    lane_cnt <= `SD '0;
                    addr_cnt <= `SD addr_cnt + ADDR_ONE;
                end else begin
                    lane_cnt <= `SD lane_cnt + LANE_ONE;
                end
            end
            if (act_fire) begin
                rd_cnt <= `SD rd_wrap ? '0 : (rd_cnt + RD_ONE);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_feed_ctrl.sv
// ============================================================================
// pe_feed_ctrl : LOAD/RUN/DRAIN producer of PE_IN_PACKET beats for the lane array
// Optional perf counters (stall_cnt, load_cyc) under PE_FEED_PERF_CNT_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module pe_feed_ctrl
    import pe_feed_ctrl_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 start,
    input  wire logic [ADDR_B:0]      num_w,
    input  wire logic [RUN_B-1:0]     run_len,
    pe_feed_if.master                 bus,
    output      logic                 busy,
    output      logic                 done
`ifdef PE_FEED_PERF_CNT_EN
    ,
    output      logic [31:0]          stall_cnt,
    output      logic [31:0]          load_cyc
`endif
);

    localparam logic [1:0] ST_IDLE  = FS_IDLE;
    localparam logic [1:0] ST_LOAD  = FS_LOAD;
    localparam logic [1:0] ST_RUN   = FS_RUN;
    localparam logic [1:0] ST_DRAIN = FS_DRAIN;

    localparam int             DR_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYC - 1);
    localparam logic [DR_W-1:0] DR_ONE  = DR_W'(1);
    localparam logic [RUN_B-1:0] RUN_ONE = RUN_B'(1);

    logic [1:0]         state;
    logic [ADDR_B:0]    num_w_q;
    logic [RUN_B-1:0]   run_len_q;
    logic [RUN_B-1:0]   run_cnt;
    logic [DR_W-1:0]    drain_cnt;
    PE_IN_PACKET        pk;

    logic [LANE_W-1:0]  lane_cnt;
    logic [ADDR_B-1:0]  wr_addr;
    logic [ADDR_B-1:0]  rd_cnt;
    logic               wt_last;
    logic               wt_fire;
    logic               act_fire;
    logic               act_last;
    logic               start_go;

    // Readies decode straight from the state register so they drop on the transition edge
    assign bus.wt_ready  = (state == ST_LOAD);
    assign bus.act_ready = (state == ST_RUN);
    assign busy          = (state != ST_IDLE);
    assign bus.pe_in_pk  = pk;

    assign wt_fire  = bus.wt_valid  & bus.wt_ready;
    assign act_fire = bus.act_valid & bus.act_ready;
    assign act_last = act_fire & (run_cnt == (run_len_q - RUN_ONE));
    assign start_go = (state == ST_IDLE) & start;

    pe_feed_addr_gen u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_go),
        .wt_fire  (wt_fire),
        .act_fire (act_fire),
        .num_w    (num_w_q),
        .lane_cnt (lane_cnt),
        .wr_addr  (wr_addr),
        .rd_cnt   (rd_cnt),
        .wt_last  (wt_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= `SD ST_IDLE;
            num_w_q   <= `SD '0;
            run_len_q <= `SD '0;
            run_cnt   <= `SD '0;
            drain_cnt <= `SD '0;
            done      <= `SD 1'b0;
        end else begin
            done <= `SD 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_w_q   <= `SD num_w;
                        run_len_q <= `SD run_len;
                        run_cnt   <= `SD '0;
                        drain_cnt <= `SD '0;
                        // An empty job still walks DRAIN so done timing is uniform
                        if ((num_w == '0) || (run_len == '0)) begin
                            state <= `SD ST_DRAIN;
                        end else begin
                            state <= `SD ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wt_last) begin
                        state <= `SD ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (act_fire) begin
                        run_cnt <= `SD run_cnt + RUN_ONE;
                        if (act_last) begin
                            state     <= `SD ST_DRAIN;
                            drain_cnt <= `SD '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DR_LAST) begin
                        state     <= `SD ST_IDLE;
                        drain_cnt <= `SD '0;
                        done      <= `SD 1'b1;
                    end else begin
                        drain_cnt <= `SD drain_cnt + DR_ONE;
                    end
                end
                default: begin
                    state <= `SD ST_IDLE;
                end
            endcase
        end
    end

    // Data fields hold between beats; only the tag and write strobes fall back to idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pk <= `SD '0;
        end else begin
            pk.PE_state <= `SD PE_INVALID;
            pk.wrb      <= `SD '0;
            if (wt_fire) begin
                pk.PE_state <= `SD PE_LOAD;
                pk.wrb      <= `SD lane_onehot(lane_cnt);
                pk.wrb_addr <= `SD wr_addr;
                pk.wrb_data <= `SD bus.wt_data;
            end else if (act_fire) begin
                pk.PE_state <= `SD act_last ? PE_LAST : PE_COMPUTE;
                pk.rdb_addr <= `SD rd_cnt;
                pk.A        <= `SD bus.act_data;
            end
        end
    end

`ifdef PE_FEED_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= `SD '0;
            load_cyc  <= `SD '0;
        end else if (start_go) begin
            stall_cnt <= `SD '0;
            load_cyc  <= `SD '0;
        end else begin
            if ((state == ST_RUN) && !bus.act_valid && (stall_cnt != '1)) begin
                stall_cnt <= `SD stall_cnt + 32'd1;
            end
            if ((state == ST_LOAD) && (load_cyc != '1)) begin
                load_cyc <= `SD load_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_feed_ctrl.sv
// ============================================================================
// tb_pe_feed_ctrl : scoreboard bench for pe_feed_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pe_feed_ctrl;
    import pe_feed_ctrl_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_B:0]     num_w = '0;
    logic [RUN_B-1:0]    run_len = '0;
    logic                busy;
    logic                done;
`ifdef PE_FEED_PERF_CNT_EN
    logic [31:0]         stall_cnt;
    logic [31:0]         load_cyc;
`endif

    pe_feed_if bus();

    pe_feed_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .num_w   (num_w),
        .run_len (run_len),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done)
`ifdef PE_FEED_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .load_cyc  (load_cyc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model of the controller, advanced once per cycle at the falling edge
    int                            m_st, m_lane, m_addr, m_rd, m_run, m_drain, m_nw, m_rl;
    bit                            m_done;
    logic [MUL_NUM*DATA_WID-1:0]   m_A;
    logic [ADDR_B-1:0]             m_rdb;
    PE_IN_PACKET                   sb_q[$];

    task automatic model_reset();
        m_st = M_IDLE; m_lane = 0; m_addr = 0; m_rd = 0; m_run = 0; m_drain = 0;
        m_nw = 0; m_rl = 0; m_done = 1'b0; m_A = '0; m_rdb = '0;
        sb_q.delete();
    endtask

    task automatic model_step();
        PE_IN_PACKET e;
        e = '0;
        m_done = 1'b0;
        case (m_st)
            M_IDLE: if (start) begin
                m_nw = int'(num_w); m_rl = int'(run_len);
                if (m_nw == 0 || m_rl == 0) begin m_st = M_DRAIN; m_drain = 0; end
                else begin m_st = M_LOAD; m_lane = 0; m_addr = 0; end
            end
            M_LOAD: if (bus.wt_valid) begin
                e.PE_state = PE_LOAD;
                e.wrb      = MUL_NUM'(1) << m_lane;
                e.wrb_addr = ADDR_B'(m_addr);
                e.wrb_data = bus.wt_data;
                sb_q.push_back(e);
                if (m_lane == MUL_NUM - 1) begin
                    m_lane = 0;
                    if (m_addr == m_nw - 1) begin m_st = M_RUN; m_rd = 0; m_run = 0; end
                    else m_addr++;
                end else m_lane++;
            end
            M_RUN: if (bus.act_valid) begin
                m_run++;
                e.PE_state = (m_run == m_rl) ? PE_LAST : PE_COMPUTE;
                e.rdb_addr = ADDR_B'(m_rd);
                e.A        = bus.act_data;
                sb_q.push_back(e);
                m_rd = (m_rd == m_nw - 1) ? 0 : m_rd + 1;
                if (m_run == m_rl) begin m_st = M_DRAIN; m_drain = 0; end
            end
            default: begin
                if (m_drain == DRAIN_CYC - 1) begin m_st = M_IDLE; m_done = 1'b1; end
                else m_drain++;
            end
        endcase
    endtask

    always @(negedge clk) begin
        PE_IN_PACKET pk;
        PE_IN_PACKET e;
        if (!reset) begin
            model_reset();
        end else begin
            pk = bus.pe_in_pk;
            check_eq("wt_ready", bus.wt_ready, m_st == M_LOAD);
            check_eq("act_ready", bus.act_ready, m_st == M_RUN);
            check_eq("busy", busy, m_st != M_IDLE);
            check_eq("done", done, m_done);
            if (pk.PE_state != PE_INVALID) begin
                if (sb_q.size() == 0) begin
                    check_eq("beat_unexp", pk.PE_state, PE_INVALID);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("pe_state", pk.PE_state, e.PE_state);
                    if (e.PE_state == PE_LOAD) begin
                        check_eq("wrb", pk.wrb, e.wrb);
                        check_eq("wrb_addr", pk.wrb_addr, e.wrb_addr);
                        check_eq("wrb_data", pk.wrb_data, e.wrb_data);
                    end else begin
                        check_eq("wrb_run", pk.wrb, 64'd0);
                        m_A   = e.A;
                        m_rdb = e.rdb_addr;
                    end
                end
            end else begin
                check_eq("wrb_idle", pk.wrb, 64'd0);
            end
            if (sb_q.size() != 0) begin
                check_eq("beat_missing", pk.PE_state, sb_q[0].PE_state);
                sb_q.delete();
            end
            check_eq("A", pk.A, m_A);
            check_eq("rdb_addr", pk.rdb_addr, m_rdb);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int nw, input int rl);
        num_w   = (ADDR_B + 1)'(nw);
        run_len = RUN_B'(rl);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_wt(input logic [DATA_WID-1:0] d);
        logic r;
        bus.wt_valid = 1'b1;
        bus.wt_data  = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); r = bus.wt_ready;
            tick();
            if (r) break;
            if (n == 39) check_eq("wt_timeout", r, 1);
        end
        bus.wt_valid = 1'b0;
    endtask

    task automatic send_act();
        logic r;
        logic [MUL_NUM*DATA_WID-1:0] d;
        for (int l = 0; l < MUL_NUM; l++) d[l*DATA_WID +: DATA_WID] = DATA_WID'($urandom);
        bus.act_valid = 1'b1;
        bus.act_data  = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); r = bus.act_ready;
            tick();
            if (r) break;
            if (n == 39) check_eq("act_timeout", r, 1);
        end
        bus.act_valid = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk); seen = done;
        end
        check_eq("done_seen", seen, 1);
        repeat (5) tick();
    endtask

    task automatic run_seq(input int nw, input int rl, input bit gaps, input bit mid_start);
        pulse_start(nw, rl);
        for (int i = 0; i < nw * MUL_NUM; i++) send_wt(DATA_WID'(i + 1));
        for (int i = 0; i < rl; i++) begin
            if (gaps && (i % 2 == 1)) begin bus.act_valid = 1'b0; tick(); end
            if (mid_start && i == 2) begin
                num_w = '0; run_len = RUN_B'(1); start = 1'b1;
                tick();
                start = 1'b0;
            end
            send_act();
        end
        wait_done();
    endtask

    task automatic zero_seq(input int nw, input int rl);
        int n;
        logic seen;
        n = 0; seen = 1'b0;
        pulse_start(nw, rl);
        while (!seen && n < 20) begin @(negedge clk); n++; seen = done; end
        check_eq("zero_done_lat", n, 4);
        repeat (3) tick();
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_pk"}, bus.pe_in_pk, 64'd0);
        check_eq({tag, "_state"}, bus.pe_in_pk.PE_state, PE_INVALID);
        check_eq({tag, "_wt_ready"}, bus.wt_ready, 0);
        check_eq({tag, "_act_ready"}, bus.act_ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        bus.wt_valid = 1'b0; bus.wt_data = '0; bus.act_valid = 1'b0; bus.act_data = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outs("rst");
        tick();
        reset = 1'b1;
        tick();

        run_seq(2, 3, 1'b0, 1'b0);
        zero_seq(0, 5);
        zero_seq(2, 0);
        run_seq(2, 4, 1'b1, 1'b0);
        run_seq(1 << ADDR_B, (1 << ADDR_B) + 1, 1'b0, 1'b0);
        run_seq(3, 6, 1'b0, 1'b1);

        // asynchronous reset in the middle of LOAD
        pulse_start(2, 3);
        for (int i = 0; i < 3; i++) send_wt(DATA_WID'(8'h40 + i));
        bus.wt_valid = 1'b1; bus.wt_data = 8'h55;
        #2 reset = 1'b0;
        #1 check_reset_outs("async");
        bus.wt_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        run_seq(2, 3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/pe_feed_ctrl.md
Name: pe_feed_ctrl

Overview:
Producer end of the PE input packet interface. It builds PE_IN_PACKET beats for a MUL_NUM-lane buffer/multiplier array.
- LOAD phase: streams weights into the per-lane buffers using wrb, wrb_addr and wrb_data.
- RUN phase: streams activation vectors on A, with rdb_addr cycling over the loaded depth and PE_state tagging each beat.
- DRAIN phase: covers the 3-stage state pipeline of the array, then signals done.

Parameters:
- DATA_WID, `CNN_XLEN: element width.
- ADDR_B, `ADDR_B: buffer address width; buffer depth = 2**ADDR_B.
- MUL_NUM, `ICP_NUM: number of lanes/multipliers.
- RUN_B, 16: width of the run-length counter.
- DRAIN_CYC, 3: cycles held in DRAIN; matches the array's state pipeline depth.

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- num_w  in  ADDR_B+1  weights per lane (1..2**ADDR_B)
- run_len  in  RUN_B  activation vectors to issue
- wt_valid  in  1  weight stream valid
- wt_data  in  DATA_WID  weight word
- wt_ready  out  1  weight accepted when wt_valid & wt_ready
- act_valid  in  1  activation stream valid
- act_data  in  MUL_NUM*DATA_WID  one element per lane
- act_ready  out  1  activation accepted when act_valid & act_ready
- pe_in_pk  out  PE_IN_PACKET  registered packet to the array
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of DRAIN

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the reset sync upstream):
  - state = IDLE.
  - pe_in_pk all zero, with PE_state = INVALID and wrb = 0.
  - wt_ready = 0, act_ready = 0, busy = 0, done = 0.
  - All counters cleared.
- Reset mid-operation: aborts immediately. No done pulse. Partially loaded buffer contents are undefined.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - Outputs are the idle packet (PE_state = INVALID, wrb = 0).
  - On start: latch num_w and run_len.
  - If either latched value is 0: go to DRAIN.
  - Otherwise: go to LOAD with addr_cnt = 0 and lane_cnt = 0.
- LOAD:
  - wt_ready = 1.
  - Per accepted weight, next cycle: pe_in_pk.wrb = one-hot(lane_cnt), wrb_addr = addr_cnt, wrb_data = wt_data, PE_state = LOAD.
  - With no handshake: wrb = 0, PE_state = INVALID.
  - Order is address-major: lane_cnt increments 0..MUL_NUM-1, then wraps to 0 and addr_cnt increments.
  - After the word at (num_w-1, MUL_NUM-1) is accepted: go to RUN and drop wt_ready the same edge.
- RUN:
  - act_ready = 1, wt_ready = 0.
  - Per accepted vector, next cycle: A[i] = act_data lane i, rdb_addr = rd_cnt, wrb = 0, PE_state = COMPUTE.
  - The beat for the final vector (issued count == run_len) carries PE_state = LAST.
  - rd_cnt increments per handshake and wraps to 0 after num_w-1.
  - Stall (no handshake): PE_state = INVALID, A holds its last value, rdb_addr holds.
  - After the last vector is accepted: go to DRAIN and drop act_ready the same edge.
- DRAIN:
  - Packet is INVALID.
  - Count DRAIN_CYC cycles, then pulse done for 1 cycle and return to IDLE.
  - busy falls in the same cycle done is high.
- Latency: a handshake in cycle N appears on pe_in_pk in cycle N+1.
- start outside IDLE: ignored.
- wt_valid outside LOAD and act_valid outside RUN: ignored.
- Counter widths: addr_cnt ADDR_B+1 bits, so num_w = 2**ADDR_B is representable; rd_cnt is ADDR_B bits; run counter is RUN_B bits.
- No arithmetic is performed on data; data passes through unmodified.

Optional Feature:
- Macro: `PE_FEED_PERF_CNT_EN`.
- Defined:
  - Adds output stall_cnt (32 bits), which counts RUN cycles with act_valid = 0.
  - Adds output load_cyc (32 bits), which counts cycles spent in LOAD.
  - Both clear on start, saturate at all-ones, and reset to 0.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package: PE_IN_PACKET and PE_STATE.
  - PE_STATE holds INVALID, LOAD, COMPUTE and LAST.
  - Add a new FEED_STATE enum (IDLE, LOAD, RUN, DRAIN).
  - `SD is used on all registered assignments.
- One natural sub-module, pe_feed_addr_gen: it owns the lane_cnt, addr_cnt and rd_cnt counters and the wrap logic. The top level keeps the FSM and packet register.

Test Plan:
- MUL_NUM=4, num_w=2, run_len=3, continuous valid:
  - Weights 1..8 yield wrb 0001, 0010, 0100, 1000, 0001, …
  - wrb_addr 0,0,0,0,1,1,1,1.
  - Then 3 COMPUTE/LAST beats with rdb_addr 0,1,0.
  - done 3 cycles after the LAST beat.
- num_w=0 or run_len=0 with start: no LOAD or COMPUTE beats; done pulses 4 cycles after start.
- act_valid toggling 1,0,1 in RUN: INVALID beat inserted; A and rdb_addr held; rd_cnt advances only on handshakes.
- num_w=2**ADDR_B, run_len=2**ADDR_B+1: the final rdb_addr wraps to 0 and the last beat is tagged LAST.
- reset low mid-LOAD: all outputs zero and INVALID immediately (asynchronous); after release, start performs a clean full sequence.
- start pulsed during RUN: ignored; counts unaffected; exactly one done.
